// File: rtl/uv_boot_pkg.sv
// Shared types for the boot copier: FSM state encoding and the bus exception code.
package uv_boot_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_RSP,
    WR_REQ,
    WR_RSP,
    FIN
  } state_t;

  localparam logic [1:0] EXCP_NONE = 2'b00;

endpackage

// File: rtl/uv_boot_copier.sv
// Boot copier: ROM->RAM word copy, one outstanding bus transaction, 4 cycles/word with zero-wait slaves (done at 4*len+1).
// Waits indefinitely on req_rdy / rsp_vld of either port; optional XOR checksum under UV_BOOT_COPIER_CHKSUM_EN.
module uv_boot_copier
  import uv_boot_pkg::*;
#(
  parameter int ALEN  = 26,
  parameter int DLEN  = 32,
  parameter int MLEN  = DLEN / 8,
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [ALEN-1:0]  src_base,
  input  logic [ALEN-1:0]  dst_base,
  input  logic [LEN_W-1:0] copy_len,
  output logic             busy,
  output logic             done,
  output logic             err,
`ifdef UV_BOOT_COPIER_CHKSUM_EN
  output logic [DLEN-1:0]  chksum,
`endif
  output logic             src_req_vld,
  input  logic             src_req_rdy,
  output logic             src_req_read,
  output logic [ALEN-1:0]  src_req_addr,
  output logic [MLEN-1:0]  src_req_mask,
  output logic [DLEN-1:0]  src_req_data,
  input  logic             src_rsp_vld,
  output logic             src_rsp_rdy,
  input  logic [1:0]       src_rsp_excp,
  input  logic [DLEN-1:0]  src_rsp_data,
  output logic             dst_req_vld,
  input  logic             dst_req_rdy,
  output logic             dst_req_read,
  output logic [ALEN-1:0]  dst_req_addr,
  output logic [MLEN-1:0]  dst_req_mask,
  output logic [DLEN-1:0]  dst_req_data,
  input  logic             dst_rsp_vld,
  output logic             dst_rsp_rdy,
  input  logic [1:0]       dst_rsp_excp,
  input  logic [DLEN-1:0]  dst_rsp_data
);

  localparam logic [ALEN-1:0] STRIDE = ALEN'(MLEN);

  state_t           state;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cnt;

  // RAM write responses carry no useful data.
  logic unused_dst_rsp;
  assign unused_dst_rsp = ^dst_rsp_data;

  // The request address registers double as the running copy pointers and
  // dst_req_data doubles as the one-word buffer, so request fields are held
  // stable for free while a slave stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      len_q        <= '0;
      cnt          <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
`ifdef UV_BOOT_COPIER_CHKSUM_EN
      chksum       <= '0;
`endif
      src_req_vld  <= 1'b0;
      src_req_read <= 1'b0;
      src_req_addr <= '0;
      src_req_mask <= '0;
      src_req_data <= '0;
      src_rsp_rdy  <= 1'b0;
      dst_req_vld  <= 1'b0;
      dst_req_read <= 1'b0;
      dst_req_addr <= '0;
      dst_req_mask <= '0;
      dst_req_data <= '0;
      dst_rsp_rdy  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            len_q        <= copy_len;
            cnt          <= '0;
            err          <= 1'b0;
`ifdef UV_BOOT_COPIER_CHKSUM_EN
            chksum       <= '0;
`endif
            src_req_addr <= src_base;
            dst_req_addr <= dst_base;
            if (copy_len != '0) begin
              state        <= RD_REQ;
              busy         <= 1'b1;
              src_req_vld  <= 1'b1;
              src_req_read <= 1'b1;
              src_req_mask <= '1;
              src_req_data <= '0;
            end else begin
              state <= FIN;
              done  <= 1'b1;
            end
          end
        end

        RD_REQ: begin
          if (src_req_rdy) begin
            src_req_vld <= 1'b0;
            src_rsp_rdy <= 1'b1;
            state       <= RD_RSP;
          end
        end

        RD_RSP: begin
          if (src_rsp_vld) begin
            src_rsp_rdy <= 1'b0;
            if (src_rsp_excp != EXCP_NONE) begin
              err   <= 1'b1;
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= FIN;
            end else begin
`ifdef UV_BOOT_COPIER_CHKSUM_EN
              chksum       <= chksum ^ src_rsp_data;
`endif
              dst_req_data <= src_rsp_data;
              dst_req_vld  <= 1'b1;
              dst_req_read <= 1'b0;
              dst_req_mask <= '1;
              state        <= WR_REQ;
            end
          end
        end

        WR_REQ: begin
          if (dst_req_rdy) begin
            dst_req_vld <= 1'b0;
            dst_rsp_rdy <= 1'b1;
            state       <= WR_RSP;
          end
        end

        WR_RSP: begin
          if (dst_rsp_vld) begin
            dst_rsp_rdy <= 1'b0;
            if (dst_rsp_excp != EXCP_NONE) begin
              err   <= 1'b1;
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= FIN;
            end else begin
              cnt          <= cnt + LEN_W'(1);
              src_req_addr <= src_req_addr + STRIDE;
              dst_req_addr <= dst_req_addr + STRIDE;
              if (cnt == len_q - LEN_W'(1)) begin
                busy  <= 1'b0;
                done  <= 1'b1;
                state <= FIN;
              end else begin
                src_req_vld  <= 1'b1;
                src_req_read <= 1'b1;
                src_req_mask <= '1;
                src_req_data <= '0;
                state        <= RD_REQ;
              end
            end
          end
        end

        FIN: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uv_boot_copier.sv
// Randomised bench for uv_boot_copier: ROM/RAM responder models, expectation queues
// filled from a word-list reference model, and a monitor that checks every bus handshake.
module tb_uv_boot_copier;

  localparam int ALEN  = 26;
  localparam int DLEN  = 32;
  localparam int MLEN  = DLEN / 8;
  localparam int LEN_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [ALEN-1:0]  src_base, dst_base;
  logic [LEN_W-1:0] copy_len;
  logic             busy, done, err;
`ifdef UV_BOOT_COPIER_CHKSUM_EN
  logic [DLEN-1:0]  chksum;
`endif
  logic             src_req_vld, src_req_rdy, src_req_read;
  logic [ALEN-1:0]  src_req_addr;
  logic [MLEN-1:0]  src_req_mask;
  logic [DLEN-1:0]  src_req_data;
  logic             src_rsp_vld, src_rsp_rdy;
  logic [1:0]       src_rsp_excp;
  logic [DLEN-1:0]  src_rsp_data;
  logic             dst_req_vld, dst_req_rdy, dst_req_read;
  logic [ALEN-1:0]  dst_req_addr;
  logic [MLEN-1:0]  dst_req_mask;
  logic [DLEN-1:0]  dst_req_data;
  logic             dst_rsp_vld, dst_rsp_rdy;
  logic [1:0]       dst_rsp_excp;
  logic [DLEN-1:0]  dst_rsp_data;

  uv_boot_copier #(.ALEN(ALEN), .DLEN(DLEN), .MLEN(MLEN), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .start(start),
    .src_base(src_base), .dst_base(dst_base), .copy_len(copy_len),
    .busy(busy), .done(done), .err(err),
`ifdef UV_BOOT_COPIER_CHKSUM_EN
    .chksum(chksum),
`endif
    .src_req_vld(src_req_vld), .src_req_rdy(src_req_rdy), .src_req_read(src_req_read),
    .src_req_addr(src_req_addr), .src_req_mask(src_req_mask), .src_req_data(src_req_data),
    .src_rsp_vld(src_rsp_vld), .src_rsp_rdy(src_rsp_rdy), .src_rsp_excp(src_rsp_excp),
    .src_rsp_data(src_rsp_data),
    .dst_req_vld(dst_req_vld), .dst_req_rdy(dst_req_rdy), .dst_req_read(dst_req_read),
    .dst_req_addr(dst_req_addr), .dst_req_mask(dst_req_mask), .dst_req_data(dst_req_data),
    .dst_rsp_vld(dst_rsp_vld), .dst_rsp_rdy(dst_rsp_rdy), .dst_rsp_excp(dst_rsp_excp),
    .dst_rsp_data(dst_rsp_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [ALEN-1:0] a; logic [DLEN-1:0] d; } wr_t;
  typedef struct { logic e; int lat; logic [DLEN-1:0] ck; } done_t;

  logic [ALEN-1:0] exp_rd_q[$];
  wr_t             exp_wr_q[$];
  done_t           exp_done_q[$];
  logic [DLEN-1:0] ram[logic [ALEN-1:0]];

  int          n_checks = 0;
  int          n_fail = 0;
  int          dones_seen = 0;
  int          start_cyc = 0;
  int          dst_excp_word = -1;
  int          dst_wr_idx = 0;
  bit          stall = 1'b0;
  logic [31:0] rom_seed = 32'h1234_5678;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [DLEN-1:0] rom_word(input logic [ALEN-1:0] a);
    return (DLEN'(a) * 32'h9E37_79B1) ^ rom_seed;
  endfunction

  // ROM responder
  initial begin
    logic rf, af, r;
    logic [ALEN-1:0] a;
    bit pend;
    int dly;
    src_req_rdy = 1'b0; src_rsp_vld = 1'b0; src_rsp_excp = 2'b00; src_rsp_data = '0;
    pend = 1'b0; dly = 0;
    forever begin
      @(negedge clk);
      rf = src_req_vld && src_req_rdy;
      af = src_rsp_vld && src_rsp_rdy;
      a  = src_req_addr;
      r  = rst;
      @(posedge clk); #1;
      if (r) begin
        pend = 1'b0; src_rsp_vld = 1'b0;
      end else begin
        if (af) begin pend = 1'b0; src_rsp_vld = 1'b0; end
        if (rf) begin
          pend = 1'b1;
          dly = stall ? int'($urandom_range(0, 3)) : 0;
          src_rsp_data = rom_word(a);
        end
        if (pend && !src_rsp_vld) begin
          if (dly == 0) src_rsp_vld = 1'b1;
          else dly--;
        end
      end
      src_req_rdy = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
  end

  // RAM responder, with optional exception on a chosen write index
  initial begin
    logic rf, af, r;
    logic [ALEN-1:0] a;
    logic [DLEN-1:0] d;
    logic [1:0] ex;
    bit pend;
    int dly;
    dst_req_rdy = 1'b0; dst_rsp_vld = 1'b0; dst_rsp_excp = 2'b00; dst_rsp_data = '0;
    pend = 1'b0; dly = 0; ex = 2'b00;
    forever begin
      @(negedge clk);
      rf = dst_req_vld && dst_req_rdy;
      af = dst_rsp_vld && dst_rsp_rdy;
      a  = dst_req_addr;
      d  = dst_req_data;
      r  = rst;
      @(posedge clk); #1;
      if (r) begin
        pend = 1'b0; dst_rsp_vld = 1'b0; dst_rsp_excp = 2'b00;
      end else begin
        if (af) begin pend = 1'b0; dst_rsp_vld = 1'b0; dst_rsp_excp = 2'b00; end
        if (rf) begin
          pend = 1'b1;
          dly = stall ? int'($urandom_range(0, 3)) : 0;
          if (dst_wr_idx == dst_excp_word) ex = 2'b01;
          else begin ex = 2'b00; ram[a] = d; end
          dst_wr_idx++;
        end
        if (pend && !dst_rsp_vld) begin
          if (dly == 0) begin dst_rsp_vld = 1'b1; dst_rsp_excp = ex; end
          else dly--;
        end
      end
      dst_req_rdy = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
  end

  // Monitor / scoreboard
  initial begin
    logic sp, dp;
    logic [ALEN-1:0] sa, da;
    logic [DLEN-1:0] dd;
    int outst;
    logic [ALEN-1:0] ea;
    wr_t ew;
    done_t ed;
    sp = 1'b0; dp = 1'b0; outst = 0; sa = '0; da = '0; dd = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        sp = 1'b0; dp = 1'b0; outst = 0;
      end else begin
        if (sp) begin
          check("src_hold_vld", src_req_vld, 1);
          check("src_hold_addr", src_req_addr, sa);
        end
        if (exp_rd_q.size() == 0) check("src_vld_unexpected", src_req_vld, 0);
        else if (src_req_vld && src_req_rdy) begin
          check("one_outstanding_rd", outst, 0);
          outst++;
          ea = exp_rd_q.pop_front();
          check("src_addr", src_req_addr, ea);
          check("src_read", src_req_read, 1);
          check("src_mask", src_req_mask, {MLEN{1'b1}});
        end
        sp = src_req_vld && !src_req_rdy;
        sa = src_req_addr;
        if (src_rsp_vld && src_rsp_rdy) outst--;

        if (dp) begin
          check("dst_hold_vld", dst_req_vld, 1);
          check("dst_hold_addr", dst_req_addr, da);
          check("dst_hold_data", dst_req_data, dd);
        end
        if (exp_wr_q.size() == 0) check("dst_vld_unexpected", dst_req_vld, 0);
        else if (dst_req_vld && dst_req_rdy) begin
          check("one_outstanding_wr", outst, 0);
          outst++;
          ew = exp_wr_q.pop_front();
          check("dst_addr", dst_req_addr, ew.a);
          check("dst_data", dst_req_data, ew.d);
          check("dst_read", dst_req_read, 0);
          check("dst_mask", dst_req_mask, {MLEN{1'b1}});
        end
        dp = dst_req_vld && !dst_req_rdy;
        da = dst_req_addr;
        dd = dst_req_data;
        if (dst_rsp_vld && dst_rsp_rdy) outst--;

        if (src_rsp_rdy && dst_rsp_rdy) check("both_rsp_rdy", 1, 0);

        if (done) begin
          check("busy_at_done", busy, 0);
          if (exp_done_q.size() == 0) check("done_unexpected", done, 0);
          else begin
            ed = exp_done_q.pop_front();
            check("err_at_done", err, ed.e);
            if (ed.lat >= 0) check("done_latency", cyc - start_cyc, ed.lat);
`ifdef UV_BOOT_COPIER_CHKSUM_EN
            check("chksum", chksum, ed.ck);
`endif
          end
          dones_seen++;
        end
      end
    end
  end

  // Reference model: the word list a copy should produce, then launch it.
  task automatic launch(input logic [ALEN-1:0] sb, input logic [ALEN-1:0] db,
                        input int len, input int excp_w);
    int n;
    bit e;
    logic [ALEN-1:0] a;
    logic [DLEN-1:0] ck;
    done_t ed;
    e = (excp_w >= 0) && (excp_w < len);
    n = e ? excp_w + 1 : len;
    ck = '0;
    for (int i = 0; i < n; i++) begin
      a = sb + ALEN'(MLEN * i);
      exp_rd_q.push_back(a);
      exp_wr_q.push_back('{db + ALEN'(MLEN * i), rom_word(a)});
      ck ^= rom_word(a);
    end
    ed.e = e; ed.lat = stall ? -1 : 4 * n + 1; ed.ck = ck;
    exp_done_q.push_back(ed);
    dst_excp_word = excp_w;
    dst_wr_idx = 0;
    @(posedge clk); #1;
    src_base = sb; dst_base = db; copy_len = LEN_W'(len);
    start = 1'b1;
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("err_clear_on_start", err, 0);
    check("busy_after_start", busy, len != 0);
  endtask

  task automatic wait_done(input int target, input bool_extra);
    int k;
    if (bool_extra) begin
      repeat (10) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
    end
    k = 0;
    while (dones_seen < target && k < 5000) begin
      @(negedge clk);
      k++;
    end
    check("done_timeout", dones_seen >= target, 1);
    repeat (4) @(negedge clk);
    check("rd_q_left", exp_rd_q.size(), 0);
    check("wr_q_left", exp_wr_q.size(), 0);
    check("done_q_left", exp_done_q.size(), 0);
    exp_rd_q.delete(); exp_wr_q.delete(); exp_done_q.delete();
  endtask

  task automatic run_copy(input logic [ALEN-1:0] sb, input logic [ALEN-1:0] db,
                          input int len, input int excp_w, input bit extra_start);
    int target;
    target = dones_seen + 1;
    launch(sb, db, len, excp_w);
    wait_done(target, extra_start);
  endtask

  initial begin
    int k;
    rst = 1'b1; start = 1'b0; src_base = '0; dst_base = '0; copy_len = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_src_vld", src_req_vld, 0);
    check("rst_dst_vld", dst_req_vld, 0);
    check("rst_src_rsp_rdy", src_rsp_rdy, 0);
    check("rst_dst_rsp_rdy", dst_rsp_rdy, 0);
    check("rst_src_addr", src_req_addr, 0);
    check("rst_dst_addr", dst_req_addr, 0);
    check("rst_dst_data", dst_req_data, 0);
    check("rst_src_mask", src_req_mask, 0);
    @(posedge clk); #1 rst = 1'b0;

    // Zero-wait basic copy plus RAM contents
    rom_seed = $urandom;
    run_copy(26'h100, 26'h2000, 4, -1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      logic [ALEN-1:0] ka;
      ka = 26'h2000 + ALEN'(4 * i);
      check("ram_word", ram.exists(ka) ? ram[ka] : ~rom_word(26'h100 + ALEN'(4 * i)),
            rom_word(26'h100 + ALEN'(4 * i)));
    end

    // Zero-length copy
    run_copy(26'h40, 26'h80, 0, -1, 1'b0);

    // Random stalls, plus a start pulse mid-copy that must be ignored
    stall = 1'b1;
    for (int t = 0; t < 3; t++) begin
      rom_seed = $urandom;
      run_copy(ALEN'($urandom) & ~ALEN'(MLEN - 1), ALEN'($urandom) & ~ALEN'(MLEN - 1), 16, -1, t == 0);
    end
    stall = 1'b0;

    // RAM exception on the second of five words, then a clean copy clears err
    rom_seed = $urandom;
    run_copy(26'h300, 26'h4000, 5, 1, 1'b0);
    run_copy(26'h300, 26'h4000, 5, -1, 1'b0);

    // Source address wrap
    run_copy(26'h3FF_FFFC, 26'h5000, 2, -1, 1'b0);

    // Reset while waiting on a read response
    stall = 1'b0;
    launch(26'h600, 26'h7000, 3, -1);
    k = 0;
    while (!src_rsp_rdy && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("reach_rd_rsp", src_rsp_rdy, 1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_src_vld", src_req_vld, 0);
    check("rst_mid_dst_vld", dst_req_vld, 0);
    check("rst_mid_src_rsp_rdy", src_rsp_rdy, 0);
    check("rst_mid_done", done, 0);
    @(posedge clk); #1;
    exp_rd_q.delete(); exp_wr_q.delete(); exp_done_q.delete();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    rom_seed = $urandom;
    run_copy(26'h600, 26'h7000, 3, -1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
